// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier controller.
//   state_t : controller state encoding (2'b11 is unused and recovers to IDLE)
//   MULT_N  : default operand width
package mult_pkg;

  localparam int unsigned MULT_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/nbit_ripple_adder.sv
// N-bit ripple-carry adder built from a chain of Full_Adder cells.
// Full_Adder ports:
//   A, B, Cin : one-bit addends and carry in
//   S, Cout   : sum bit and carry out
// nbit_ripple_adder ports:
//   A, B : N-bit addends
//   Cin  : carry into bit 0
//   S    : N-bit sum
//   Cout : carry out of bit N-1
module Full_Adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

module nbit_ripple_adder #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] S,
  output logic         Cout
);

  logic [N:0] carry;

  assign carry[0] = Cin;
  assign Cout     = carry[N];

  for (genvar i = 0; i < N; i++) begin : g_fa
    Full_Adder u_fa (
      .A   (A[i]),
      .B   (B[i]),
      .Cin (carry[i]),
      .S   (S[i]),
      .Cout(carry[i+1])
    );
  end

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential N-bit unsigned shift-add multiplier. One shared ripple adder is
// reused over N add/shift iterations; a Start in IDLE launches a multiply and
// Done pulses once when the 2N-bit Product is ready.
// Ports:
//   Clk          : rising-edge clock
//   Rst_n        : synchronous active-low reset
//   Start        : multiply request, only honoured in IDLE
//   Multiplicand : operand M, captured with the accepted Start
//   Multiplier   : operand Q, captured with the accepted Start
//   Busy         : high while iterating (CALC)
//   Done         : one-cycle pulse, Product valid from this cycle on
//   Product      : M*Q, held until the next result is written
module shift_add_mult_ctrl
  import mult_pkg::*;
#(
  parameter  int unsigned N  = MULT_N,
  localparam int unsigned CW = $clog2(N + 1)
) (
  input  logic           Clk,
  input  logic           Rst_n,
  input  logic           Start,
  input  logic [N-1:0]   Multiplicand,
  input  logic [N-1:0]   Multiplier,
  output logic           Busy,
  output logic           Done,
  output logic [2*N-1:0] Product
);

  state_t        state;
  logic [N-1:0]  m;
  logic [N-1:0]  acc;
  logic [N-1:0]  q;
  logic [CW-1:0] count;

  logic [N-1:0]  addend;
  logic [N-1:0]  sum;
  logic          c;

  // Adding zero when Q[0] is clear makes {C,ACC} = {0,ACC} without a mux on the result.
  always_comb begin
    addend = '0;
    if (q[0]) addend = m;
  end

  nbit_ripple_adder #(.N(N)) u_adder (
    .A   (acc),
    .B   (addend),
    .Cin (1'b0),
    .S   (sum),
    .Cout(c)
  );

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state   <= IDLE;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Product <= '0;
      m       <= '0;
      acc     <= '0;
      q       <= '0;
      count   <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        CALC: begin
          // Add and shift in one step: the carry becomes the new ACC MSB and
          // the sum LSB moves into Q, so {C,ACC,Q} shifts right as one word.
          acc   <= {c, sum[N-1:1]};
          q     <= {sum[0], q[N-1:1]};
          count <= count + 1'b1;
          if (count == CW'(N - 1)) begin
            state <= DONE;
            Busy  <= 1'b0;
          end
        end
        DONE: begin
          Product <= {acc, q};
          Done    <= 1'b1;
          state   <= IDLE;
        end
        // IDLE and the unused 2'b11 code share this branch, so 2'b11 acts as IDLE.
        default: begin
          if (Start) begin
            m     <= Multiplicand;
            q     <= Multiplier;
            acc   <= '0;
            count <= '0;
            state <= CALC;
            Busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Self-checking bench for shift_add_mult_ctrl: an N=8 and an N=4 instance.
// Expected products and acceptance edges are queued when a Start is accepted
// and compared against Product and Done timing when Done appears.
module tb_shift_add_mult_ctrl;

  localparam int unsigned N8 = 8;
  localparam int unsigned N4 = 4;

  typedef struct {
    logic [63:0] prod;
    int unsigned k;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start8, start4;
  logic [7:0]  m8, q8;
  logic [3:0]  m4, q4;
  logic        busy8, done8, busy4, done4;
  logic [15:0] product8;
  logic [7:0]  product4;

  int unsigned cyc = 0;
  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned last_k8 = 0;
  exp_t sb8[$];
  exp_t sb4[$];
  exp_t e8, e4;

  shift_add_mult_ctrl #(.N(N8)) dut8 (
    .Clk(clk), .Rst_n(rst_n), .Start(start8),
    .Multiplicand(m8), .Multiplier(q8),
    .Busy(busy8), .Done(done8), .Product(product8)
  );

  shift_add_mult_ctrl #(.N(N4)) dut4 (
    .Clk(clk), .Rst_n(rst_n), .Start(start4),
    .Multiplicand(m4), .Multiplier(q4),
    .Busy(busy4), .Done(done4), .Product(product4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Scoreboard consumers: every Done must match the oldest outstanding multiply.
  always @(posedge clk) begin
    #1;
    if (done8) begin
      check("n8_done_busy_overlap", 64'(busy8), 64'd0);
      if (sb8.size() == 0) begin
        check("n8_unexpected_done", 64'd1, 64'd0);
      end else begin
        e8 = sb8.pop_front();
        check("n8_product", 64'(product8), e8.prod);
        check("n8_latency", 64'(cyc - e8.k), 64'(N8 + 1));
      end
    end
    if (done4) begin
      check("n4_done_busy_overlap", 64'(busy4), 64'd0);
      if (sb4.size() == 0) begin
        check("n4_unexpected_done", 64'd1, 64'd0);
      end else begin
        e4 = sb4.pop_front();
        check("n4_product", 64'(product4), e4.prod);
        check("n4_latency", 64'(cyc - e4.k), 64'(N4 + 1));
      end
    end
  end

  task automatic wait_neg(input int unsigned target);
    do @(negedge clk); while (cyc < target);
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start8 = 1'b1;
    m8 = a;
    q8 = b;
    @(posedge clk);
    #1;
    last_k8 = cyc;
    sb8.push_back('{prod: 64'(a) * 64'(b), k: cyc});
    start8 = 1'b0;
  endtask

  task automatic drain8();
    for (int i = 0; i < 40; i++) begin
      if (sb8.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("n8_drain", 64'(sb8.size()), 64'd0);
  endtask

  task automatic drain4();
    for (int i = 0; i < 40; i++) begin
      if (sb4.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("n4_drain", 64'(sb4.size()), 64'd0);
  endtask

  initial begin
    int unsigned k;
    int unsigned busy_cnt;
    int unsigned prevk;
    logic [63:0] held;
    logic [63:0] prev_exp;

    rst_n = 1'b0;
    start8 = 1'b0; m8 = '0; q8 = '0;
    start4 = 1'b0; m4 = '0; q4 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_done8", 64'(done8), 64'd0);
    check("rst_product8", 64'(product8), 64'd0);
    check("rst_product4", 64'(product4), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // Basic 13*11 with busy-window length
    issue8(8'd13, 8'd11);
    check("t1_busy_first", 64'(busy8), 64'd1);
    busy_cnt = 1;
    repeat (11) begin
      @(posedge clk);
      #1;
      busy_cnt += busy8;
    end
    check("t1_busy_len", 64'(busy_cnt), 64'(N8));
    drain8();
    check("t1_hold", 64'(product8), 64'd143);

    // Carry into ACC MSB and zero operands
    issue8(8'd255, 8'd255);
    drain8();
    check("t2_maxmax", 64'(product8), 64'hFE01);
    issue8(8'd0, 8'd200);
    drain8();
    issue8(8'd200, 8'd0);
    drain8();

    // Start ignored in CALC and DONE, then held Start accepted in IDLE
    issue8(8'd9, 8'd9);
    k = last_k8;
    wait_neg(k + 3);
    start8 = 1'b1; m8 = 8'd7; q8 = 8'd7;
    @(negedge clk) start8 = 1'b0;
    wait_neg(k + N8);
    start8 = 1'b1; m8 = 8'd7; q8 = 8'd7;
    @(posedge clk);
    @(posedge clk);
    #1;
    sb8.push_back('{prod: 64'd49, k: cyc});
    check("t3_accept_after_done", 64'(cyc - k), 64'(N8 + 2));
    start8 = 1'b0;
    drain8();
    check("t3_second_product", 64'(product8), 64'd49);

    // Mid-calculation reset discards the multiply
    issue8(8'd100, 8'd3);
    k = last_k8;
    wait_neg(k + 3);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t4_busy", 64'(busy8), 64'd0);
    check("t4_done", 64'(done8), 64'd0);
    check("t4_product", 64'(product8), 64'd0);
    sb8.delete();
    @(negedge clk) rst_n = 1'b1;
    repeat (14) @(posedge clk);
    issue8(8'd5, 8'd6);
    drain8();
    check("t4_after_reset", 64'(product8), 64'd30);

    // N=4 exhaustive sweep, Start held high for back-to-back issue
    held = '0;
    prevk = 0;
    prev_exp = '0;
    for (int unsigned a = 0; a < 16; a++) begin
      for (int unsigned b = 0; b < 16; b++) begin
        if (a == 0 && b == 0) begin
          @(negedge clk);
        end else begin
          wait_neg(prevk + 4);
          check("n4_hold", 64'(product4), held);
          held = prev_exp;
          wait_neg(prevk + 5);
        end
        start4 = 1'b1;
        m4 = 4'(a);
        q4 = 4'(b);
        @(posedge clk);
        #1;
        if (!(a == 0 && b == 0))
          check("n4_issue_interval", 64'(cyc - prevk), 64'(N4 + 2));
        prevk = cyc;
        prev_exp = 64'(a * b);
        sb4.push_back('{prod: 64'(a * b), k: cyc});
      end
    end
    start4 = 1'b0;
    drain4();
    check("n4_final_hold", 64'(product4), 64'd225);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
